// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
//
// Decodes the immediate format from the instruction opcode and produces an XLEN-wide
// immediate (RV32 or RV64 extension rules, including shamt and OP-IMM-32 forms).
// Results pass through a one-entry valid/ready output register backed by a one-entry
// skid buffer, so the upstream handshake never depends combinationally on out_ready.
//
// Parameters:
//   XLEN       immediate width, 32 or 64
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   inst is valid this cycle
//   in_ready   block can accept an instruction (= !skid_valid)
//   inst       raw 32-bit instruction word
//   out_valid  imm / imm_type / unknown are valid
//   out_ready  downstream accepts the output this cycle
//   imm        extended immediate
//   imm_type   0=I 1=S 2=B 3=U 4=J 5=Z 6=SH 7=NONE
//   unknown    opcode not in the decode map
//
// Build option:
//   IMM_GEN_PIPE_CSR_EN  when defined, SYSTEM instructions with inst[14] set decode
//                        as Z (CSR zimm). When undefined, all SYSTEM encodings give NONE.

module imm_gen_pipe #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            unknown
);

  typedef enum logic [2:0] {
    TypeI    = 3'd0,
    TypeS    = 3'd1,
    TypeB    = 3'd2,
    TypeU    = 3'd3,
    TypeJ    = 3'd4,
    TypeZ    = 3'd5,
    TypeSh   = 3'd6,
    TypeNone = 3'd7
  } imm_type_e;

  localparam logic [6:0] OpLoad     = 7'b0000011;
  localparam logic [6:0] OpJalr     = 7'b1100111;
  localparam logic [6:0] OpOpImm    = 7'b0010011;
  localparam logic [6:0] OpOpImm32  = 7'b0011011;
  localparam logic [6:0] OpStore    = 7'b0100011;
  localparam logic [6:0] OpBranch   = 7'b1100011;
  localparam logic [6:0] OpLui      = 7'b0110111;
  localparam logic [6:0] OpAuipc    = 7'b0010111;
  localparam logic [6:0] OpJal      = 7'b1101111;
  localparam logic [6:0] OpSystem   = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       itype;
    logic            unknown;
  } payload_t;

  localparam payload_t PayloadReset = '{imm: '0, itype: TypeNone, unknown: 1'b0};

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;

  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // All sign-extending formats take their sign from inst[31].
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] shamt5, shamt6;

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s  = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};

  payload_t dec;

  always_comb begin
    dec = '{imm: '0, itype: TypeNone, unknown: 1'b0};
    case (opcode)
      OpLoad, OpJalr: begin
        dec.imm   = imm_i;
        dec.itype = TypeI;
      end
      OpOpImm: begin
        if (is_shift) begin
          // RV64 shifts carry a 6-bit shamt; RV32 only 5 bits.
          dec.imm   = (XLEN == 64) ? shamt6 : shamt5;
          dec.itype = TypeSh;
        end else begin
          dec.imm   = imm_i;
          dec.itype = TypeI;
        end
      end
      OpOpImm32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            // Word shifts always use a 5-bit shamt.
            dec.imm   = shamt5;
            dec.itype = TypeSh;
          end else begin
            dec.imm   = imm_i;
            dec.itype = TypeI;
          end
        end else begin
          dec.unknown = 1'b1;
        end
      end
      OpStore: begin
        dec.imm   = imm_s;
        dec.itype = TypeS;
      end
      OpBranch: begin
        dec.imm   = imm_b;
        dec.itype = TypeB;
      end
      OpLui, OpAuipc: begin
        dec.imm   = imm_u;
        dec.itype = TypeU;
      end
      OpJal: begin
        dec.imm   = imm_j;
        dec.itype = TypeJ;
      end
      OpSystem: begin
`ifdef IMM_GEN_PIPE_CSR_EN
        // inst[14] selects the immediate CSR forms (csrrwi/csrrsi/csrrci).
        if (inst[14]) begin
          dec.imm   = {{(XLEN-5){1'b0}}, inst[19:15]};
          dec.itype = TypeZ;
        end
`endif
        // Remaining SYSTEM encodings are known but carry no immediate.
      end
      default: begin
        dec.unknown = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register + skid buffer
  // ---------------------------------------------------------------------------
  logic     out_valid_q, out_valid_d;
  logic     skid_valid_q, skid_valid_d;
  payload_t out_q, out_d;
  payload_t skid_q, skid_d;
  logic     accept;

  // in_ready depends only on local state, never on out_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-output move can happen.
      if (out_ready) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_d       = dec;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = dec;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= PayloadReset;
      skid_valid_q <= 1'b0;
      skid_q       <= PayloadReset;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign imm       = out_q.imm;
  assign imm_type  = out_q.itype;
  assign unknown   = out_q.unknown;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe. Two instances (XLEN=32 and XLEN=64)
// share all inputs so RV32 and RV64 expectations are checked on the same stimulus.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] inst;
  logic        out_ready;

  logic        in_ready32, out_valid32, unknown32;
  logic [31:0] imm32;
  logic [2:0]  type32;
  logic        in_ready64, out_valid64, unknown64;
  logic [63:0] imm64;
  logic [2:0]  type64;

  int checks;
  int failures;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready32),
    .inst      (inst),
    .out_valid (out_valid32),
    .out_ready (out_ready),
    .imm       (imm32),
    .imm_type  (type32),
    .unknown   (unknown32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready64),
    .inst      (inst),
    .out_valid (out_valid64),
    .out_ready (out_ready),
    .imm       (imm64),
    .imm_type  (type64),
    .unknown   (unknown64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction with out_ready high; returns #1 after the capturing edge.
  task automatic issue_one(input logic [31:0] w);
    in_valid  = 1'b1;
    inst      = w;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inst     = 32'h0;
  endtask

  task automatic idle_cycle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid32, in_ready32, imm32, type32, unknown32} !== {1'b0, 1'b1, 32'h0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL reset32 got v=%b r=%b imm=%h t=%0d u=%b want v=0 r=1 imm=0 t=7 u=0",
               out_valid32, in_ready32, imm32, type32, unknown32);
    end
    checks++;
    if ({out_valid64, in_ready64, imm64, type64, unknown64} !== {1'b0, 1'b1, 64'h0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL reset64 got v=%b r=%b imm=%h t=%0d u=%b want v=0 r=1 imm=0 t=7 u=0",
               out_valid64, in_ready64, imm64, type64, unknown64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_i_format();
    issue_one(32'hFFF00093);
    checks++;
    if ({out_valid32, imm32, type32, unknown32} !== {1'b1, 32'hFFFF_FFFF, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL i_fmt32 got v=%b imm=%h t=%0d u=%b want v=1 imm=ffffffff t=0 u=0",
               out_valid32, imm32, type32, unknown32);
    end
    checks++;
    if ({out_valid64, imm64, type64, unknown64} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL i_fmt64 got v=%b imm=%h t=%0d u=%b want v=1 imm=ffffffffffffffff t=0 u=0",
               out_valid64, imm64, type64, unknown64);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3] = '{32'hFE112E23, 32'hFE000CE3, 32'h0010006F};
    logic [31:0] exp   [3] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0800};
    logic [2:0]  typ   [3] = '{3'd1, 3'd2, 3'd4};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      inst     = words[i];
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid32, imm32, type32, unknown32} !== {1'b1, exp[i], typ[i], 1'b0}) begin
        failures++;
        $display("FAIL b2b32[%0d] got v=%b imm=%h t=%0d want v=1 imm=%h t=%0d",
                 i, out_valid32, imm32, type32, exp[i], typ[i]);
      end
      checks++;
      if ({out_valid64, imm64, type64} !== {1'b1, {{32{exp[i][31]}}, exp[i]}, typ[i]}) begin
        failures++;
        $display("FAIL b2b64[%0d] got v=%b imm=%h t=%0d want v=1 imm=%h t=%0d",
                 i, out_valid64, imm64, type64, {{32{exp[i][31]}}, exp[i]}, typ[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid32 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got out_valid=%b want 0", out_valid32);
    end
  endtask

  task automatic test_shift_u();
    logic [31:0] words [5] = '{32'h41F0D093, 32'h800000B7, 32'h0200D093, 32'h0010009B,
                               32'h0210109B};
    // {imm, type, unknown} per instance
    logic [35:0] e32 [5] = '{{32'd31, 3'd6, 1'b0}, {32'h8000_0000, 3'd3, 1'b0},
                             {32'd0, 3'd6, 1'b0}, {32'd0, 3'd7, 1'b1}, {32'd0, 3'd7, 1'b1}};
    logic [67:0] e64 [5] = '{{64'd31, 3'd6, 1'b0}, {64'hFFFF_FFFF_8000_0000, 3'd3, 1'b0},
                             {64'd32, 3'd6, 1'b0}, {64'd1, 3'd0, 1'b0}, {64'd1, 3'd6, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      issue_one(words[i]);
      checks++;
      if ({out_valid32, imm32, type32, unknown32} !== {1'b1, e32[i]}) begin
        failures++;
        $display("FAIL shift_u32[%0d] got v=%b imm=%h t=%0d u=%b want v=1 {imm,t,u}=%h",
                 i, out_valid32, imm32, type32, unknown32, e32[i]);
      end
      checks++;
      if ({out_valid64, imm64, type64, unknown64} !== {1'b1, e64[i]}) begin
        failures++;
        $display("FAIL shift_u64[%0d] got v=%b imm=%h t=%0d u=%b want v=1 {imm,t,u}=%h",
                 i, out_valid64, imm64, type64, unknown64, e64[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [4] = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
    int          idx   [7] = '{0, 1, 2, 2, 2, 3, 0};
    int          eimm  [7] = '{1, 1, 1, 2, 3, 4, 0};
    logic [6:0]  or_v, iv_v, ir_v, ov_v;
    logic [31:0] got [$];
    or_v = 7'b1111001;
    iv_v = 7'b0111111;
    ir_v = 7'b1110011;
    ov_v = 7'b0111111;
    idle_cycle();
    for (int c = 0; c < 7; c++) begin
      out_ready = or_v[c];
      in_valid  = iv_v[c];
      inst      = words[idx[c]];
      checks++;
      if ({in_ready32, in_ready64} !== {2{ir_v[c]}}) begin
        failures++;
        $display("FAIL bp_in_ready[c%0d] got %b/%b want %b", c + 1, in_ready32, in_ready64,
                 ir_v[c]);
      end
      if (out_valid32 && out_ready) got.push_back(imm32);
      @(posedge clk);
      #1;
      if (ov_v[c]) begin
        checks++;
        if ({out_valid32, imm32, type32, out_valid64, imm64} !==
            {1'b1, 32'(eimm[c]), 3'd0, 1'b1, 64'(eimm[c])}) begin
          failures++;
          $display("FAIL bp_out[c%0d] got v=%b imm=%h t=%0d v64=%b imm64=%h want imm=%0d",
                   c + 1, out_valid32, imm32, type32, out_valid64, imm64, eimm[c]);
        end
      end else begin
        checks++;
        if ({out_valid32, out_valid64} !== 2'b00) begin
          failures++;
          $display("FAIL bp_drain got out_valid=%b/%b want 0", out_valid32, out_valid64);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got.size() != 4) begin
      failures++;
      $display("FAIL bp_count got %0d outputs want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== 32'(k + 1)) begin
          failures++;
          $display("FAIL bp_order[%0d] got %h want %0d", k, got[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_and_unknown();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inst      = 32'h00500093;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    inst      = 32'h00600093;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if ({out_valid32, in_ready32} !== 2'b10) begin
      failures++;
      $display("FAIL rst_fill got v=%b r=%b want v=1 r=0", out_valid32, in_ready32);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid32, in_ready32, imm32, type32, unknown32} !== {1'b0, 1'b1, 32'h0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL rst_async got v=%b r=%b imm=%h t=%0d u=%b want v=0 r=1 imm=0 t=7 u=0",
               out_valid32, in_ready32, imm32, type32, unknown32);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid64, in_ready64, imm64, type64} !== {1'b0, 1'b1, 64'h0, 3'd7}) begin
      failures++;
      $display("FAIL rst_edge64 got v=%b r=%b imm=%h t=%0d want v=0 r=1 imm=0 t=7",
               out_valid64, in_ready64, imm64, type64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue_one(32'h0000007F);
    checks++;
    if ({out_valid32, imm32, type32, unknown32} !== {1'b1, 32'h0, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL unknown32 got v=%b imm=%h t=%0d u=%b want v=1 imm=0 t=7 u=1",
               out_valid32, imm32, type32, unknown32);
    end
    checks++;
    if ({out_valid64, imm64, type64, unknown64} !== {1'b1, 64'h0, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL unknown64 got v=%b imm=%h t=%0d u=%b want v=1 imm=0 t=7 u=1",
               out_valid64, imm64, type64, unknown64);
    end
  endtask

  task automatic test_csr();
    logic [35:0] exp_csr;
`ifdef IMM_GEN_PIPE_CSR_EN
    exp_csr = {32'd5, 3'd5, 1'b0};
`else
    exp_csr = {32'd0, 3'd7, 1'b0};
`endif
    issue_one(32'h3002D073);
    checks++;
    if ({out_valid32, imm32, type32, unknown32} !== {1'b1, exp_csr}) begin
      failures++;
      $display("FAIL csrrwi32 got v=%b imm=%h t=%0d u=%b want v=1 {imm,t,u}=%h",
               out_valid32, imm32, type32, unknown32, exp_csr);
    end
    checks++;
    if ({imm64, type64, unknown64} !== {32'h0, exp_csr}) begin
      failures++;
      $display("FAIL csrrwi64 got imm=%h t=%0d u=%b want {imm,t,u}=%h",
               imm64, type64, unknown64, {32'h0, exp_csr});
    end
    issue_one(32'h00000073);
    checks++;
    if ({out_valid32, imm32, type32, unknown32} !== {1'b1, 32'h0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL ecall got v=%b imm=%h t=%0d u=%b want v=1 imm=0 t=7 u=0",
               out_valid32, imm32, type32, unknown32);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    inst      = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_i_format();
    test_back_to_back();
    test_shift_u();
    test_backpressure();
    test_reset_mid_and_unknown();
    test_csr();
    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It decodes the immediate format directly from the instruction opcode and supports RV32 and RV64 sign-extension, including shift-amount and `OP-IMM-32` forms. It adds a one-cycle valid/ready pipeline stage with a skid buffer, so fetch and execute stay decoupled at full throughput. It sits between the instruction register and the execute-stage operand mux.

## Interface
- `XLEN`, 32: immediate output width. Legal values are 32 and 64 only.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `inst` is valid this cycle.
- `in_ready` output 1: block can accept an instruction. Equals `!skid_valid`; no combinational path from `out_ready`.
- `inst` input 32: raw instruction word.
- `out_valid` output 1: `imm`, `imm_type` and `unknown` are valid.
- `out_ready` input 1: downstream accepts the output this cycle.
- `imm` output XLEN: extended immediate.
- `imm_type` output 3: format code. 0 = I, 1 = S, 2 = B, 3 = U, 4 = J, 5 = Z (CSR zimm), 6 = SH (shamt), 7 = NONE.
- `unknown` output 1: opcode is not in the decode map.

## Operation
- Opcode map, using `inst[6:0]`:
  - I format: 0000011, 1100111, 0010011.
  - S format: 0100011.
  - B format: 1100011.
  - U format: 0110111, 0010111.
  - J format: 1101111.
  - SYSTEM (1110011): see Configuration.
  - 0011011 (`OP-IMM-32`): I format only when XLEN = 64. Otherwise `unknown` = 1.
  - Any other opcode: type NONE, `imm` = 0, `unknown` = 1.
- SH override: for 0010011 with funct3 001 or 101, the type is SH.
  - XLEN = 32: `imm` = zero-extended `inst[24:20]`.
  - XLEN = 64: `imm` = zero-extended `inst[25:20]`.
  - For 0011011, SH always uses `inst[24:20]`.
- Immediate bit fields:
  - I: `inst[31:20]`.
  - S: {`inst[31:25]`, `inst[11:7]`}.
  - B: {`inst[31]`, `inst[7]`, `inst[30:25]`, `inst[11:8]`, 0}.
  - U: {`inst[31:12]`, 12'b0}.
  - J: {`inst[31]`, `inst[19:12]`, `inst[20]`, `inst[30:21]`, 0}.
- Sign extension: I, S, B, U and J are sign-extended from `inst[31]` to XLEN. For U with XLEN = 64, this extends bits 63:32.
- Z and SH are zero-extended.
- Decode is combinational on `inst`. Results are captured only on acceptance (`in_valid && in_ready`).
- Storage:
  - Output register: `out_valid` plus its payload.
  - One skid entry: `skid_valid` plus its payload.
- Acceptance cases:
  - Output register empty, or output consumed this cycle (`out_ready`), with the skid empty: the input goes straight to the output register.
  - Output register full and `!out_ready`: the input goes to the skid, and `skid_valid` is set.
  - Skid full and `out_ready`: the skid moves to the output register. A new input cannot arrive that cycle, because `in_ready` = 0.
- While `out_valid && !out_ready`, `imm`, `imm_type` and `unknown` hold stable.
- Ordering is strict FIFO. Nothing is dropped or duplicated.

## Timing
- Latency: 1 cycle from acceptance to `out_valid`, when the path is unstalled.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- After a one-cycle stall, `in_ready` falls in the cycle after the skid fills. It rises in the cycle after the skid drains.
- Reset values, applied asynchronously:
  - `out_valid` = 0, `skid_valid` = 0, so `in_ready` = 1.
  - `imm` = 0, `imm_type` = 7, `unknown` = 0.
- Reset mid-transfer discards both entries. The first post-reset acceptance behaves as from empty.
- Simultaneous accept and consume with the skid empty: the output register is overwritten with the new entry, and `out_valid` stays 1.

## Configuration
- `IMM_GEN_PIPE_CSR_EN` defined:
  - SYSTEM with `inst[14]` = 1 gives type Z, `imm` = zero-extended `inst[19:15]`.
  - All other SYSTEM encodings give NONE, `imm` = 0, `unknown` = 0.
- `IMM_GEN_PIPE_CSR_EN` undefined: every SYSTEM encoding gives NONE, `imm` = 0, `unknown` = 0. No zimm logic is present.

## Test plan
- I, XLEN = 32: 0xFFF00093 → one cycle later `imm` = 0xFFFFFFFF, type 0. With XLEN = 64, `imm` = 0xFFFFFFFFFFFFFFFF.
- S, B, J back-to-back, `out_ready` = 1:
  - 0xFE112E23 → 0xFFFFFFFC, type 1.
  - 0xFE000CE3 → 0xFFFFFFF8, type 2.
  - 0x0010006F → 0x00000800, type 4.
  - Expect three consecutive output cycles with no bubbles.
- Shift and U:
  - 0x41F0D093 (srai by 31) → `imm` = 31, type 6.
  - 0x800000B7 (lui) → 0x80000000, type 3.
  - With XLEN = 64, lui → 0xFFFFFFFF80000000.
- Back-pressure:
  - Stream 4 instructions with `out_ready` low for cycles 2–3.
  - Expect `in_ready` to drop for exactly the stall window.
  - Outputs hold stable while stalled, all 4 arrive in order, and there are no duplicates.
- Reset and unknown:
  - Assert `rst_n` = 0 with both entries full → next edge shows `out_valid` = 0, `in_ready` = 1, `imm` = 0, type 7.
  - After release, 0x0000007F → `unknown` = 1, `imm` = 0, type 7.
- Macro: 0x3002D073 (csrrwi) → with `IMM_GEN_PIPE_CSR_EN`, `imm` = 5, type 5. Without it, `imm` = 0, type 7, `unknown` = 0.
